result_streamer: RTL

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/tpu_pkg.sv | 13 +
 rtl/result_slot.sv | 57 +++++
 rtl/result_streamer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU result path.
// Holds the streamer FSM state enum plus the matrix and slot sizing.
package tpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    localparam int ELEMS_PER_MATRIX = 4;
    localparam int NUM_SLOTS        = 2;

endpackage

// File: rtl/result_slot.sv
// One 2x2 result matrix buffer with per-column capture flags.
// elems is beat-ordered (row-major): C00, C01, C10, C11 from the low slice up.
module result_slot
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_col1,
    input  logic                  cap_col2,
    input  logic                  commit,
    input  logic [DATA_W-1:0]     col1_row0,
    input  logic [DATA_W-1:0]     col1_row1,
    input  logic [DATA_W-1:0]     col2_row0,
    input  logic [DATA_W-1:0]     col2_row1,
    output logic [4*DATA_W-1:0]   elems,
    output logic                  complete,
    output logic                  partial
);

    logic [DATA_W-1:0] c00, c01, c10, c11;
    logic              got_col1, got_col2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c00      <= '0;
            c01      <= '0;
            c10      <= '0;
            c11      <= '0;
            got_col1 <= 1'b0;
            got_col2 <= 1'b0;
        end else begin
            if (cap_col1) begin
                c00 <= col1_row0;
                c10 <= col1_row1;
            end
            if (cap_col2) begin
                c01 <= col2_row0;
                c11 <= col2_row1;
            end
            // Flags clear on commit so the slot can be refilled; data stays for streaming.
            if (commit) begin
                got_col1 <= 1'b0;
                got_col2 <= 1'b0;
            end else begin
                got_col1 <= got_col1 | cap_col1;
                got_col2 <= got_col2 | cap_col2;
            end
        end
    end

    assign complete = (got_col1 | cap_col1) & (got_col2 | cap_col2);
    assign partial  = got_col1 | got_col2;
    assign elems    = {c11, c10, c01, c00};

endmodule

// File: rtl/result_streamer.sv
// Ping-pong buffer that captures 2x2 accumulator results and streams them row-major.
// Optional RESULT_STREAMER_TAG_EN adds a 4-bit per-matrix sequence tag on m_tag.
module result_streamer
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc1_full,
    input  logic              acc2_full,
    input  logic [DATA_W-1:0] acc1_mem_0,
    input  logic [DATA_W-1:0] acc1_mem_1,
    input  logic [DATA_W-1:0] acc2_mem_0,
    input  logic [DATA_W-1:0] acc2_mem_1,
`ifdef RESULT_STREAMER_TAG_EN
    output logic [3:0]        m_tag,
`endif
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] LAST_BEAT  = 2'(ELEMS_PER_MATRIX - 1);
    localparam logic [1:0] COUNT_FULL = 2'(NUM_SLOTS);

    stream_state_e     state, state_next;
    logic              full1_q, full2_q;
    logic              fill_ptr, rd_ptr;
    logic [1:0]        count, count_next;
    logic [1:0]        beat;
    logic              rise1, rise2, accept, cap1, cap2, commit, xfer, done;
    logic [NUM_SLOTS-1:0] slot_complete, slot_partial;
    logic [4*DATA_W-1:0]  slot_elems [NUM_SLOTS];
    logic [4*DATA_W-1:0]  cur_elems;
    logic [DATA_W-1:0]    beat_data;

    assign rise1  = acc1_full & ~full1_q;
    assign rise2  = acc2_full & ~full2_q;
    assign accept = (count != COUNT_FULL);
    assign cap1   = rise1 & accept;
    assign cap2   = rise2 & accept;
    assign commit = accept & slot_complete[fill_ptr];
    assign xfer   = m_valid & m_ready;
    assign done   = xfer & (beat == LAST_BEAT);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        result_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .cap_col1  (cap1 && (fill_ptr == 1'(i))),
            .cap_col2  (cap2 && (fill_ptr == 1'(i))),
            .commit    (commit && (fill_ptr == 1'(i))),
            .col1_row0 (acc1_mem_0),
            .col1_row1 (acc1_mem_1),
            .col2_row0 (acc2_mem_0),
            .col2_row1 (acc2_mem_1),
            .elems     (slot_elems[i]),
            .complete  (slot_complete[i]),
            .partial   (slot_partial[i])
        );
    end

    always_comb begin
        count_next = count;
        if (commit && !done)
            count_next = count + 2'd1;
        else if (!commit && done)
            count_next = count - 2'd1;
    end

    // Transition on next occupancy so a commit into an empty streamer shows m_valid one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != 2'd0) state_next = STREAM;
            STREAM:  if (done && count_next == 2'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            full1_q  <= 1'b0;
            full2_q  <= 1'b0;
            fill_ptr <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            beat     <= 2'd0;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            full1_q <= acc1_full;
            full2_q <= acc2_full;
            count   <= count_next;
            if (commit) fill_ptr <= ~fill_ptr;
            if (done)   rd_ptr   <= ~rd_ptr;
            if (xfer)   beat     <= beat + 2'd1;
            if ((rise1 | rise2) && !accept) overflow <= 1'b1;
        end
    end

    assign cur_elems = slot_elems[rd_ptr];

    always_comb begin
        beat_data = '0;
        case (beat)
            2'd0: beat_data = cur_elems[0*DATA_W +: DATA_W];
            2'd1: beat_data = cur_elems[1*DATA_W +: DATA_W];
            2'd2: beat_data = cur_elems[2*DATA_W +: DATA_W];
            2'd3: beat_data = cur_elems[3*DATA_W +: DATA_W];
            default: beat_data = '0;
        endcase
    end

    assign m_valid = (state == STREAM);
    assign m_data  = m_valid ? beat_data : '0;
    assign m_last  = m_valid && (beat == LAST_BEAT);
    assign busy    = (count != 2'd0) || (|slot_partial);

`ifdef RESULT_STREAMER_TAG_EN
    logic [3:0] tag_cnt;
    logic [3:0] slot_tag [NUM_SLOTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_cnt <= 4'd0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_tag[i] <= 4'd0;
        end else if (commit) begin
            slot_tag[fill_ptr] <= tag_cnt;
            tag_cnt            <= tag_cnt + 4'd1;
        end
    end

    assign m_tag = m_valid ? slot_tag[rd_ptr] : 4'd0;
`endif

endmodule
